// File: rtl/disc_flipper.sv
// disc_flipper: places the mover's disc and flips an opponent run along
// one validated direction in the shared board RAM, then reports the result.
module disc_flipper #(
  parameter int ADDR_W  = 7,
  parameter int MAX_RUN = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic              player,
  input  logic              place_i,
  input  logic [ADDR_W-1:0] s_addr_in,
  input  logic [ADDR_W-1:0] step_in,
  input  logic [1:0]        data_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        data_out,
  output logic              wren_o,
  output logic              ctrl_mem,
  output logic              busy_o,
  output logic              done_o,
  output logic              flip_ok_o,
  output logic [3:0]        flip_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    PLACE,
    ADVANCE,
    READ,
    CHECK,
    WRITE,
    DONE
  } state_t;

  localparam logic [3:0] RUN_LIM = 4'(MAX_RUN);

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] step;
  logic [1:0]        colour;
  logic [3:0]        count;
  logic [1:0]        opp;

  // colours 01/10 are bitwise complements of each other
  assign opp = ~colour;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur          <= '0;
      step         <= '0;
      colour       <= 2'b00;
      count        <= 4'd0;
      flip_ok_o    <= 1'b0;
      flip_count_o <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            cur          <= s_addr_in;
            step         <= step_in;
            colour       <= player ? 2'b10 : 2'b01;
            count        <= 4'd0;
            flip_ok_o    <= 1'b0;
            flip_count_o <= 4'd0;
            state        <= place_i ? PLACE : ADVANCE;
          end
        end
        PLACE: state <= ADVANCE;
        ADVANCE: begin
          cur   <= cur + step;
          state <= READ;
        end
        READ: state <= CHECK;
        CHECK: begin
          if (data_in == opp && count < RUN_LIM) begin
            state <= WRITE;
          end else begin
            flip_ok_o    <= (data_in == colour);
            flip_count_o <= count;
            state        <= DONE;
          end
        end
        WRITE: begin
          count <= count + 4'd1;
          state <= ADVANCE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign addr_out = cur;
  assign data_out = colour;
  assign wren_o   = (state == PLACE) || (state == WRITE);
  assign ctrl_mem = (state == PLACE) || (state == ADVANCE) ||
                    (state == READ)  || (state == CHECK) ||
                    (state == WRITE);
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);

endmodule

// File: tb/tb_disc_flipper.sv
// tb_disc_flipper: board RAM model plus directed and random flip runs
// checked against a cell-walking reference model.
module tb_disc_flipper;

  localparam int MR = 8;

  logic       clock;
  logic       reset;
  logic       start_i;
  logic       player;
  logic       place_i;
  logic [6:0] s_addr_in;
  logic [6:0] step_in;
  logic [1:0] data_in;
  logic [6:0] addr_out;
  logic [1:0] data_out;
  logic       wren_o;
  logic       ctrl_mem;
  logic       busy_o;
  logic       done_o;
  logic       flip_ok_o;
  logic [3:0] flip_count_o;

  disc_flipper #(.ADDR_W(7), .MAX_RUN(MR)) dut (
    .clock(clock),
    .reset(reset),
    .start_i(start_i),
    .player(player),
    .place_i(place_i),
    .s_addr_in(s_addr_in),
    .step_in(step_in),
    .data_in(data_in),
    .addr_out(addr_out),
    .data_out(data_out),
    .wren_o(wren_o),
    .ctrl_mem(ctrl_mem),
    .busy_o(busy_o),
    .done_o(done_o),
    .flip_ok_o(flip_ok_o),
    .flip_count_o(flip_count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] mem[128];
  logic [1:0] base[128];
  logic       load_req;
  logic [6:0] act_wa[$];
  logic [1:0] act_wd[$];
  logic [6:0] exp_wa[$];
  logic [1:0] exp_wd[$];
  int n_cmp;
  int n_bad;

  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < 128; i++) mem[i] <= base[i];
    end else if (wren_o) begin
      mem[addr_out] <= data_out;
      act_wa.push_back(addr_out);
      act_wd.push_back(data_out);
    end
    if (start_i && !busy_o) begin
      act_wa.delete();
      act_wd.delete();
    end
    data_in <= mem[addr_out];
  end

  task automatic fill_base(input logic [1:0] v);
    for (int i = 0; i < 128; i++) base[i] = v;
  endtask

  task automatic load_board();
    @(posedge clock); #1;
    load_req = 1'b1;
    @(posedge clock); #1;
    load_req = 1'b0;
  endtask

  function automatic bit wlist_same();
    if (act_wa.size() != exp_wa.size()) return 1'b0;
    foreach (exp_wa[i])
      if (act_wa[i] !== exp_wa[i] || act_wd[i] !== exp_wd[i]) return 1'b0;
    return 1'b1;
  endfunction

  // lat = cycle (1 = first cycle after the start edge) where done_o is seen
  task automatic run_op(input logic [6:0] org, input logic [6:0] stp,
                        input logic pl, input logic pc,
                        input int ig1, input int ig2, output int lat);
    @(posedge clock); #1;
    s_addr_in = org;
    step_in   = stp;
    player    = pl;
    place_i   = pc;
    start_i   = 1'b1;
    @(posedge clock); #1;
    start_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      if (done_o) begin
        lat = c;
        break;
      end
      if (c == ig1 || c == ig2) begin
        start_i   = 1'b1;
        s_addr_in = org + 7'd9;
        step_in   = stp + 7'd1;
        player    = ~pl;
        place_i   = ~pc;
      end
      @(posedge clock); #1;
      start_i = 1'b0;
    end
  endtask

  // walk the board cell by cell, as the rules describe
  task automatic ref_model(input logic [6:0] org, input logic [6:0] stp,
                           input logic pl, input logic pc,
                           output bit ok, output int cnt, output int lt);
    logic [1:0] w[128];
    logic [1:0] own;
    logic [1:0] opp;
    int a;
    own = pl ? 2'b10 : 2'b01;
    opp = pl ? 2'b01 : 2'b10;
    for (int i = 0; i < 128; i++) w[i] = mem[i];
    exp_wa.delete();
    exp_wd.delete();
    if (pc) begin
      w[org] = own;
      exp_wa.push_back(org);
      exp_wd.push_back(own);
    end
    a = int'(org);
    cnt = 0;
    ok = 1'b0;
    while (1) begin
      a = (a + int'(stp)) % 128;
      if (w[a] == opp) begin
        if (cnt == MR) break;
        w[a] = own;
        exp_wa.push_back(7'(a));
        exp_wd.push_back(own);
        cnt++;
      end else begin
        ok = (w[a] == own);
        break;
      end
    end
    lt = int'(pc) + 4 * cnt + 4;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({addr_out, data_out, wren_o, ctrl_mem, busy_o, done_o,
         flip_ok_o, flip_count_o} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b wren=%b ctrl=%b cnt=%0d",
               busy_o, wren_o, ctrl_mem, flip_count_o);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if ({busy_o, done_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy_o, done_o);
    end
  endtask

  task automatic check_s1(input string tag, input int lat);
    exp_wa = {7'd33, 7'd34};
    exp_wd = {2'b01, 2'b01};
    n_cmp++;
    if (lat !== 9) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want 9", tag, lat);
    end
    n_cmp++;
    if ({flip_ok_o, flip_count_o} !== 5'b1_0001) begin
      n_bad++;
      $display("FAIL %s_result: got ok=%b cnt=%0d want ok=1 cnt=1",
               tag, flip_ok_o, flip_count_o);
    end
    n_cmp++;
    if (!wlist_same()) begin
      n_bad++;
      $display("FAIL %s_writes: got %0d writes want 2 (33,34<-01)",
               tag, act_wa.size());
    end
    n_cmp++;
    if (mem[35] !== 2'b01) begin
      n_bad++;
      $display("FAIL %s_cell35: got %b want 01", tag, mem[35]);
    end
  endtask

  task automatic test_place_flip();
    int lat;
    fill_base(2'b00);
    base[34] = 2'b10;
    base[35] = 2'b01;
    load_board();
    run_op(7'd33, 7'd1, 1'b0, 1'b1, -1, -1, lat);
    check_s1("s1", lat);
    @(posedge clock); #1;
    n_cmp++;
    if ({done_o, flip_ok_o, flip_count_o} !== 6'b0_1_0001) begin
      n_bad++;
      $display("FAIL s1_hold: got done=%b ok=%b cnt=%0d want 0 1 1",
               done_o, flip_ok_o, flip_count_o);
    end
  endtask

  task automatic test_wrap();
    int lat;
    fill_base(2'b00);
    base[45] = 2'b01;
    base[35] = 2'b01;
    base[25] = 2'b10;
    load_board();
    run_op(7'd55, 7'h76, 1'b1, 1'b1, -1, -1, lat);
    exp_wa = {7'd55, 7'd45, 7'd35};
    exp_wd = {2'b10, 2'b10, 2'b10};
    n_cmp++;
    if (lat !== 13) begin
      n_bad++;
      $display("FAIL s2_latency: got %0d want 13", lat);
    end
    n_cmp++;
    if ({flip_ok_o, flip_count_o} !== 5'b1_0010) begin
      n_bad++;
      $display("FAIL s2_result: got ok=%b cnt=%0d want ok=1 cnt=2",
               flip_ok_o, flip_count_o);
    end
    n_cmp++;
    if (!wlist_same()) begin
      n_bad++;
      $display("FAIL s2_writes: got %0d writes want 3 (55,45,35<-10)",
               act_wa.size());
    end
  endtask

  task automatic test_no_place();
    int lat;
    fill_base(2'b00);
    base[34] = 2'b10;
    load_board();
    run_op(7'd33, 7'd1, 1'b0, 1'b0, -1, -1, lat);
    exp_wa = {7'd34};
    exp_wd = {2'b01};
    n_cmp++;
    if (lat !== 8 || {flip_ok_o, flip_count_o} !== 5'b0_0001) begin
      n_bad++;
      $display("FAIL s3_empty_end: got lat=%0d ok=%b cnt=%0d want 8 0 1",
               lat, flip_ok_o, flip_count_o);
    end
    n_cmp++;
    if (!wlist_same()) begin
      n_bad++;
      $display("FAIL s3_writes: got %0d writes want 1 (34<-01)", act_wa.size());
    end
    base[34] = 2'b11;
    load_board();
    run_op(7'd33, 7'd1, 1'b0, 1'b0, -1, -1, lat);
    n_cmp++;
    if (lat !== 4 || {flip_ok_o, flip_count_o} !== 5'b0_0000) begin
      n_bad++;
      $display("FAIL s3_border: got lat=%0d ok=%b cnt=%0d want 4 0 0",
               lat, flip_ok_o, flip_count_o);
    end
    n_cmp++;
    if (act_wa.size() !== 0) begin
      n_bad++;
      $display("FAIL s3_border_writes: got %0d want 0", act_wa.size());
    end
  endtask

  task automatic test_max_run();
    int lat;
    fill_base(2'b10);
    load_board();
    run_op(7'd0, 7'd1, 1'b0, 1'b0, -1, -1, lat);
    exp_wa.delete();
    exp_wd.delete();
    for (int i = 1; i <= MR; i++) begin
      exp_wa.push_back(7'(i));
      exp_wd.push_back(2'b01);
    end
    n_cmp++;
    if (lat !== 36 || {flip_ok_o, flip_count_o} !== 5'b0_1000) begin
      n_bad++;
      $display("FAIL s4_max_run: got lat=%0d ok=%b cnt=%0d want 36 0 8",
               lat, flip_ok_o, flip_count_o);
    end
    n_cmp++;
    if (!wlist_same() || mem[9] !== 2'b10) begin
      n_bad++;
      $display("FAIL s4_writes: got %0d writes cell9=%b want 8 and 10",
               act_wa.size(), mem[9]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int hit;
    fill_base(2'b00);
    base[45] = 2'b01;
    base[35] = 2'b01;
    base[25] = 2'b10;
    load_board();
    @(posedge clock); #1;
    s_addr_in = 7'd55;
    step_in   = 7'h76;
    player    = 1'b1;
    place_i   = 1'b1;
    start_i   = 1'b1;
    @(posedge clock); #1;
    start_i = 1'b0;
    hit = -1;
    for (int c = 1; c <= 20; c++) begin
      if (wren_o && c > 1) begin
        hit = c;
        break;
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (hit !== 5) begin
      n_bad++;
      $display("FAIL s5_write_cycle: got %0d want 5", hit);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({wren_o, ctrl_mem, busy_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL s5_async_drop: got wren=%b ctrl=%b busy=%b want 000",
               wren_o, ctrl_mem, busy_o);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    fill_base(2'b00);
    base[34] = 2'b10;
    base[35] = 2'b01;
    load_board();
    run_op(7'd33, 7'd1, 1'b0, 1'b1, -1, -1, lat);
    check_s1("s5_after", lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit eok;
    int ecnt;
    int elat;
    fill_base(2'b00);
    base[34] = 2'b10;
    base[35] = 2'b01;
    load_board();
    run_op(7'd33, 7'd1, 1'b0, 1'b1, 3, 8, lat);
    check_s1("s6", lat);
    ref_model(7'd36, 7'h7F, 1'b1, 1'b1, eok, ecnt, elat);
    run_op(7'd36, 7'h7F, 1'b1, 1'b1, -1, -1, lat);
    n_cmp++;
    if (lat !== elat || flip_ok_o !== eok || int'(flip_count_o) !== ecnt) begin
      n_bad++;
      $display("FAIL s6_next_start: got lat=%0d ok=%b cnt=%0d want %0d %b %0d",
               lat, flip_ok_o, flip_count_o, elat, eok, ecnt);
    end
    n_cmp++;
    if (!wlist_same()) begin
      n_bad++;
      $display("FAIL s6_next_writes: got %0d writes want %0d",
               act_wa.size(), exp_wa.size());
    end
  endtask

  task automatic test_random();
    int lat;
    bit eok;
    int ecnt;
    int elat;
    logic pl;
    logic pc;
    logic [6:0] org;
    logic [6:0] stp;
    int r;
    for (int it = 0; it < 16; it++) begin
      pl = 1'($urandom_range(0, 1));
      pc = 1'($urandom_range(0, 1));
      org = 7'($urandom_range(0, 127));
      stp = 7'($urandom_range(1, 127));
      for (int i = 0; i < 128; i++) begin
        r = $urandom_range(0, 7);
        if (r < 5) base[i] = pl ? 2'b01 : 2'b10;
        else if (r < 6) base[i] = pl ? 2'b10 : 2'b01;
        else base[i] = (r == 6) ? 2'b00 : 2'b11;
      end
      load_board();
      ref_model(org, stp, pl, pc, eok, ecnt, elat);
      run_op(org, stp, pl, pc, -1, -1, lat);
      n_cmp++;
      if (lat !== elat) begin
        n_bad++;
        $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, elat);
      end
      n_cmp++;
      if (flip_ok_o !== eok) begin
        n_bad++;
        $display("FAIL rnd%0d_ok: got %b want %b", it, flip_ok_o, eok);
      end
      n_cmp++;
      if (int'(flip_count_o) !== ecnt) begin
        n_bad++;
        $display("FAIL rnd%0d_count: got %0d want %0d", it, flip_count_o, ecnt);
      end
      n_cmp++;
      if (!wlist_same()) begin
        n_bad++;
        $display("FAIL rnd%0d_writes: got %0d writes want %0d",
                 it, act_wa.size(), exp_wa.size());
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    start_i = 1'b0;
    player = 1'b0;
    place_i = 1'b0;
    s_addr_in = 7'd0;
    step_in = 7'd0;
    load_req = 1'b0;
    test_reset();
    test_place_flip();
    test_wrap();
    test_no_place();
    test_max_run();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disc_flipper.md
Name: disc_flipper

Overview:
Write-side companion of the per-direction move validator. Once a direction is validated, the main/move controller starts this block with the same origin, step and player. It optionally places the player's disc at the origin, then walks along the direction and overwrites each opponent disc with the player's colour. It stops at the first own-colour disc and reports completion and the flip count. It shares the single-port board RAM, 7-bit address, 2-bit cells, with the validator, and owns the RAM only while ctrl_mem is high.

Parameters:
ADDR_W, 7, board RAM address width.
MAX_RUN, 8, maximum opponent discs flipped per run; guards against a corrupted board. Must be ≤15.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle start request; accepted only when busy_o=0
player  in  1  0=black (colour 01), 1=white (colour 10); latched on start
place_i  in  1  1: write the player colour at the origin first; latched on start
s_addr_in  in  ADDR_W  origin cell address; latched on start
step_in  in  ADDR_W  two's-complement direction offset, added modulo 2^ADDR_W; latched on start
data_in  in  2  RAM read data; valid one cycle after the address is presented
addr_out  out  ADDR_W  RAM address
data_out  out  2  RAM write data (always the latched player colour)
wren_o  out  1  RAM write enable
ctrl_mem  out  1  1 = this block drives the RAM bus
busy_o  out  1  1 in any state except IDLE
done_o  out  1  one-cycle completion pulse
flip_ok_o  out  1  result, valid while done_o=1; held until next start
flip_count_o  out  4  discs flipped in the last run, excluding the origin; held until next start

Behaviour:
- Cell encoding: 00 empty, 01 black, 10 white, 11 border.
- Reset (async, any state) forces IDLE. All outputs go to 0, internal cur/step/colour/count registers go to 0, and wren_o drops immediately.
- All outputs are registered or decoded from the state register. No combinational path from data_in to wren_o.
- States: IDLE, PLACE, ADVANCE, READ, CHECK, WRITE, DONE.
- IDLE: ctrl_mem=0, wren_o=0. On start_i=1:
  - latch cur=s_addr_in, step, colour=player?10:01 and place;
  - clear count, flip_ok_o and flip_count_o;
  - go to PLACE if place_i=1, else ADVANCE.
- PLACE: ctrl_mem=1, addr_out=cur, data_out=colour, wren_o=1 for exactly one cycle. Next state is ADVANCE.
- ADVANCE: cur <= cur+step, truncated to ADDR_W; addr_out shows the new cur from the next cycle; wren_o=0. Next state is READ.
- READ: addr_out=cur, wren_o=0; the RAM samples the address. Next state is CHECK.
- CHECK: data_in is valid.
  - opponent colour and count<MAX_RUN: go to WRITE;
  - opponent colour and count==MAX_RUN: go to DONE with ok=0, no write;
  - own colour: go to DONE with ok=1;
  - 00 or 11: go to DONE with ok=0.
- WRITE: addr_out=cur, data_out=colour, wren_o=1 for one cycle; count++. Next state is ADVANCE.
- DONE: done_o=1, flip_ok_o=result, flip_count_o=count, ctrl_mem=0. Next state is IDLE.
- ctrl_mem is 1 in every state from PLACE through CHECK/WRITE.
- start_i while busy_o=1 is ignored; it is neither queued nor does it change any latched value.
- Writes happen as runs are discovered. An ok=0 result after flips means board/validator inconsistency, and the already-written cells are not restored. The controller must start only on validated directions.
- Latency, start sampled at edge 0, with P=place_i and N=flips: done_o asserts at cycle P+4N+4 and lasts 1 cycle.

Test Plan:
1. Black, place=1, origin 33, step 1; RAM 34=10, 35=01 -> writes 33←01 then 34←01; done_o at cycle 9, ok=1, count=1; 35 is untouched.
2. White, place=1, origin 55, step 7'h76 (-10); RAM 45=01, 35=01, 25=10 -> addresses wrap to 45, 35, 25; writes 55, 45, 35 ←10; ok=1, count=2, done_o at cycle 13.
3. Black, place=0, origin 33, step 1; RAM 34=10, 35=00 -> single write 34←01, no origin write; ok=0, count=1. Repeat with 34=11 -> no writes, ok=0, count=0, done_o at cycle 4.
4. All-opponent RAM (every cell 10), black, step 1, MAX_RUN=8 -> exactly 8 writes; the 9th opponent read ends with ok=0, count=8, no 9th write.
5. Assert reset during a WRITE cycle of scenario 2 -> wren_o, ctrl_mem and busy_o fall without waiting for an edge; after release, IDLE, and a fresh start of scenario 1 completes correctly.
6. Pulse start_i again at cycles 3 and 8 of scenario 1 with different s_addr_in/player -> ignored; results are identical to scenario 1, and a start on the cycle after done_o is accepted.
